bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter IO_BASE, default 32'hF000_0000, base of the 4 KiB IO window (bits [11:0] zero).
REQ-003 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port busAddress  input  32  byte address from CPU initiator.
REQ-006 SHALL have port busDataIn  input  32  write data from CPU.
REQ-007 SHALL have port busWriteEnable  input  1  1 = write, 0 = read.
REQ-008 SHALL have port busDataOut  output  32  registered read data to CPU.
REQ-009 SHALL have port gpioIn  input  8  asynchronous external inputs.
REQ-010 SHALL have port gpioOut  output  8  GPIO output register.
REQ-011 SHALL have port timerIrq  output  1  timer interrupt, level.

Function
REQ-012 SHALL use word index busAddress[31:2]; busAddress[1:0] ignored, no byte lanes.
REQ-013 SHALL decode RAM when busAddress < RAM_WORDS*4; IO when busAddress[31:12] == IO_BASE[31:12]; anything else unmapped.
REQ-014 SHALL register busDataOut every clk from the current busAddress: data valid one cycle after address is presented, matching the CPU Fetch0->Fetch1->Decode timing.
REQ-015 SHALL return 0 on unmapped or undefined-offset reads; writes there ignored.
REQ-016 SHALL write busDataIn on every rising edge with busWriteEnable=1; a held write repeats idempotently.
REQ-017 SHALL be read-before-write: the read in the write cycle returns old data, the next cycle new data.
REQ-018 SHALL implement IO offsets: 0x00 GPIO_OUT RW [7:0]; 0x04 GPIO_IN RO; 0x08 TIMER_COUNT RW; 0x0C TIMER_COMPARE RW; 0x10 TIMER_CTRL (bit0 enable RW, bit1 pending, write-1-to-clear).
REQ-019 SHALL synchronize gpioIn through two flops; GPIO_IN reads the second stage (2-cycle input latency).
REQ-020 SHALL increment TIMER_COUNT by 1 per cycle while enable=1.
REQ-021 SHALL, when enable=1 and COUNT == COMPARE, set pending and load COUNT=0 next cycle (period COMPARE+1 cycles).
REQ-022 SHALL give a CPU write to TIMER_COUNT priority over increment/wrap in the same cycle.
REQ-023 SHALL give hardware pending-set priority over a simultaneous W1C.
REQ-024 SHALL wrap TIMER_COUNT 32'hFFFF_FFFF -> 0 with no other effect when COMPARE never matches.
REQ-025 SHALL drive timerIrq = pending AND enable, registered.

Reset
REQ-026 SHALL on reset set busDataOut=0, gpioOut=0, sync flops=0, COUNT=0, COMPARE=32'hFFFF_FFFF, enable=0, pending=0, timerIrq=0.
REQ-027 SHALL not initialize RAM contents; reset mid-write SHALL suppress that write to IO registers, RAM write is don't-care.

Configuration
REQ-028 SHALL with RISKOW_TIMER_EN defined include the timer per REQ-020..025.
REQ-029 SHALL without RISKOW_TIMER_EN make offsets 0x08-0x10 read 0, ignore writes, tie timerIrq=0, with no timer flops.

Structure
REQ-030 SHALL take IO offsets, TIMER_CTRL bit positions and the IO_BASE default from shared package riskow_bus_pkg.
REQ-031 SHALL place the timer in sub-module bus_timer (count, compare, ctrl, irq), instantiated only under RISKOW_TIMER_EN.

Verification
REQ-032 SHALL cover RAM: write 0xDEADBEEF at 0x10, read 0x10 -> 0xDEADBEEF one cycle later; read 0x13 -> same word.
REQ-033 SHALL cover read-before-write: hold address 0x20 (old 0x1), write 0x2 -> busDataOut 0x1 in that cycle, 0x2 next.
REQ-034 SHALL cover unmapped: write/read 0x8000_0000 -> reads 0, RAM unchanged.
REQ-035 SHALL cover GPIO: write 0xA5 to IO_BASE+0x00 -> gpioOut=0xA5; gpioIn=0x3C -> GPIO_IN reads 0x3C after 2-cycle sync plus 1-cycle read latency.
REQ-036 SHALL cover timer: COMPARE=4, enable=1 -> timerIrq rises after 5 cycles, COUNT=0; W1C in the same cycle as a match -> pending stays 1.
REQ-037 SHALL cover build without RISKOW_TIMER_EN: IO_BASE+0x08 reads 0 after writing 0x55, timerIrq stays 0.

Source files
------------

// File: rtl/riskow_bus_pkg.sv
// Shared bus definitions: IO window default base, IO register offsets,
// TIMER_CTRL bit positions and the address-region decoder.
package riskow_bus_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hF000_0000;

  // Byte offsets inside the 4 KiB IO window
  localparam logic [11:0] OFF_GPIO_OUT      = 12'h000;
  localparam logic [11:0] OFF_GPIO_IN       = 12'h004;
  localparam logic [11:0] OFF_TIMER_COUNT   = 12'h008;
  localparam logic [11:0] OFF_TIMER_COMPARE = 12'h00C;
  localparam logic [11:0] OFF_TIMER_CTRL    = 12'h010;

  // TIMER_CTRL fields
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_PEND_BIT = 1;

  typedef enum logic [1:0] {
    REGION_UNMAPPED = 2'd0,
    REGION_RAM      = 2'd1,
    REGION_IO       = 2'd2
  } region_e;

  // RAM wins over IO if the two ever overlap; everything else is unmapped.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [19:0] io_page,
                                            input logic [32:0] ram_bytes);
    if ({1'b0, addr} < ram_bytes)       return REGION_RAM;
    else if (addr[31:12] == io_page)    return REGION_IO;
    else                                return REGION_UNMAPPED;
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Free-running compare timer: COUNT, COMPARE, CTRL (enable, sticky pending)
// and a level interrupt. Only built when RISKOW_TIMER_EN is defined.
import riskow_bus_pkg::*;

module bus_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_count,
  input  logic        i_wr_compare,
  input  logic        i_wr_ctrl,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic [31:0] o_ctrl,
  output logic        o_irq
);

  logic [31:0] r_count, r_compare;
  logic        r_en, r_pend, r_irq;
  logic        w_match;
  logic [31:0] w_count_nxt;
  logic        w_en_nxt, w_pend_nxt;

  // Next-state: CPU COUNT write beats wrap/increment; hardware pending-set
  // beats a same-cycle write-1-to-clear.
  always_comb begin
    w_match     = r_en && (r_count == r_compare);
    w_count_nxt = r_count;
    if (i_wr_count)   w_count_nxt = i_wdata;
    else if (w_match) w_count_nxt = '0;
    else if (r_en)    w_count_nxt = r_count + 32'd1;
    w_en_nxt   = i_wr_ctrl ? i_wdata[CTRL_EN_BIT] : r_en;
    w_pend_nxt = r_pend;
    if (i_wr_ctrl && i_wdata[CTRL_PEND_BIT]) w_pend_nxt = 1'b0;
    if (w_match)                             w_pend_nxt = 1'b1;
  end

  // Timer state; irq flop tracks pending & enable of the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_compare <= 32'hFFFF_FFFF;
      r_en      <= 1'b0;
      r_pend    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      if (i_wr_compare) r_compare <= i_wdata;
      r_en      <= w_en_nxt;
      r_pend    <= w_pend_nxt;
      r_irq     <= w_pend_nxt & w_en_nxt;
    end
  end

  // CTRL read view
  always_comb begin
    o_ctrl                = '0;
    o_ctrl[CTRL_EN_BIT]   = r_en;
    o_ctrl[CTRL_PEND_BIT] = r_pend;
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_irq     = r_irq;

endmodule

// File: rtl/bus_responder.sv
// CPU bus responder: word RAM, GPIO and (with RISKOW_TIMER_EN defined) a
// compare timer in a 4 KiB IO window. Read data is registered one cycle
// after the address; reads in a write cycle see the old contents.
import riskow_bus_pkg::*;

module bus_responder #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] busAddress,
  input  logic [31:0] busDataIn,
  input  logic        busWriteEnable,
  output logic [31:0] busDataOut,
  input  logic [7:0]  gpioIn,
  output logic [7:0]  gpioOut,
  output logic        timerIrq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  logic [31:0]   r_mem [RAM_WORDS];
  logic [31:0]   r_dout;
  logic [7:0]    r_gpio_out, r_gpio_s1, r_gpio_s2;
  region_e       w_region;
  logic [11:0]   w_io_off;
  logic [AW-1:0] w_ram_idx;
  logic          w_io_wr;
  logic [31:0]   w_rdata;
  logic          w_unused_ok;

  // Byte lanes do not exist; the low address bits are deliberately dropped.
  assign w_unused_ok = ^busAddress[1:0];
  assign w_region    = decode_region(busAddress, IO_BASE[31:12], RAM_BYTES);
  assign w_io_off    = {busAddress[11:2], 2'b00};
  assign w_ram_idx   = busAddress[AW+1:2];
  assign w_io_wr     = busWriteEnable && (w_region == REGION_IO);

`ifdef RISKOW_TIMER_EN
  logic [31:0] w_t_count, w_t_compare, w_t_ctrl;

  bus_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_wr_count   (w_io_wr && (w_io_off == OFF_TIMER_COUNT)),
    .i_wr_compare (w_io_wr && (w_io_off == OFF_TIMER_COMPARE)),
    .i_wr_ctrl    (w_io_wr && (w_io_off == OFF_TIMER_CTRL)),
    .i_wdata      (busDataIn),
    .o_count      (w_t_count),
    .o_compare    (w_t_compare),
    .o_ctrl       (w_t_ctrl),
    .o_irq        (timerIrq)
  );
`else
  assign timerIrq = 1'b0;
`endif

  // Read mux from current register/RAM contents (pre-write values)
  always_comb begin
    w_rdata = '0;
    case (w_region)
      REGION_RAM: w_rdata = r_mem[w_ram_idx];
      REGION_IO: begin
        case (w_io_off)
          OFF_GPIO_OUT:      w_rdata = {24'd0, r_gpio_out};
          OFF_GPIO_IN:       w_rdata = {24'd0, r_gpio_s2};
`ifdef RISKOW_TIMER_EN
          OFF_TIMER_COUNT:   w_rdata = w_t_count;
          OFF_TIMER_COMPARE: w_rdata = w_t_compare;
          OFF_TIMER_CTRL:    w_rdata = w_t_ctrl;
`endif
          default:           w_rdata = '0;
        endcase
      end
      default: w_rdata = '0;
    endcase
  end

  // RAM write port; contents are never reset
  always_ff @(posedge clk) begin
    if (busWriteEnable && (w_region == REGION_RAM)) r_mem[w_ram_idx] <= busDataIn;
  end

  // Registered read data, GPIO output register and two-flop input sync
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout     <= '0;
      r_gpio_out <= '0;
      r_gpio_s1  <= '0;
      r_gpio_s2  <= '0;
    end else begin
      r_dout    <= w_rdata;
      r_gpio_s1 <= gpioIn;
      r_gpio_s2 <= r_gpio_s1;
      if (w_io_wr && (w_io_off == OFF_GPIO_OUT)) r_gpio_out <= busDataIn[7:0];
    end
  end

  assign busDataOut = r_dout;
  assign gpioOut    = r_gpio_out;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder; timer scenarios follow RISKOW_TIMER_EN.
module tb_bus_responder;

  localparam logic [31:0] IOB = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] busAddress, busDataIn, busDataOut;
  logic        busWriteEnable;
  logic [7:0]  gpioIn, gpioOut;
  logic        timerIrq;
  int          checks = 0;
  int          errors = 0;

  bus_responder #(.RAM_WORDS(1024), .IO_BASE(IOB)) dut (
    .clk(clk), .reset(reset), .busAddress(busAddress), .busDataIn(busDataIn),
    .busWriteEnable(busWriteEnable), .busDataOut(busDataOut),
    .gpioIn(gpioIn), .gpioOut(gpioOut), .timerIrq(timerIrq)
  );

  always #5 clk = ~clk;

  // one clock, then settle 1 time unit past the edge
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    busAddress = a; busDataIn = d; busWriteEnable = 1'b1;
    cyc();
    busWriteEnable = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    busAddress = a; busWriteEnable = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; busAddress = IOB + 32'h0C; busDataIn = 32'h0;
    busWriteEnable = 1'b0; gpioIn = 8'h00;
    cyc(); cyc();
    checks++; if (busDataOut !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp %h", busDataOut, 32'h0); end
    checks++; if (gpioOut !== 8'h0) begin errors++; $display("FAIL reset_gpio got %h exp %h", gpioOut, 8'h0); end
    checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", timerIrq); end
    reset = 1'b0;
    bus_rd(IOB + 32'h0C);
`ifdef RISKOW_TIMER_EN
    checks++; if (busDataOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare got %h exp %h", busDataOut, 32'hFFFF_FFFF); end
`else
    checks++; if (busDataOut !== 32'h0) begin errors++; $display("FAIL reset_compare got %h exp %h", busDataOut, 32'h0); end
`endif
  endtask

  task automatic test_ram();
    bus_wr(32'h10, 32'hDEAD_BEEF);
    bus_rd(32'h10);
    checks++; if (busDataOut !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd got %h exp %h", busDataOut, 32'hDEAD_BEEF); end
    bus_rd(32'h13);
    checks++; if (busDataOut !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd_lowbits got %h exp %h", busDataOut, 32'hDEAD_BEEF); end
  endtask

  task automatic test_read_before_write();
    bus_wr(32'h20, 32'h1);
    busAddress = 32'h20; busDataIn = 32'h2; busWriteEnable = 1'b1;
    cyc();
    checks++; if (busDataOut !== 32'h1) begin errors++; $display("FAIL rbw_old got %h exp %h", busDataOut, 32'h1); end
    busWriteEnable = 1'b0;
    cyc();
    checks++; if (busDataOut !== 32'h2) begin errors++; $display("FAIL rbw_new got %h exp %h", busDataOut, 32'h2); end
  endtask

  task automatic test_unmapped();
    bus_wr(32'h0, 32'h1111_1111);
    bus_wr(32'h8000_0000, 32'h1234_5678);
    bus_rd(32'h8000_0000);
    checks++; if (busDataOut !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %h exp %h", busDataOut, 32'h0); end
    bus_rd(32'h0);
    checks++; if (busDataOut !== 32'h1111_1111) begin errors++; $display("FAIL unmapped_ram got %h exp %h", busDataOut, 32'h1111_1111); end
    bus_wr(IOB + 32'h20, 32'hFFFF_FFFF);
    bus_rd(IOB + 32'h20);
    checks++; if (busDataOut !== 32'h0) begin errors++; $display("FAIL io_undef got %h exp %h", busDataOut, 32'h0); end
  endtask

  task automatic test_gpio();
    bus_wr(IOB, 32'h0000_00A5);
    checks++; if (gpioOut !== 8'hA5) begin errors++; $display("FAIL gpio_out got %h exp %h", gpioOut, 8'hA5); end
    bus_rd(IOB);
    checks++; if (busDataOut !== 32'hA5) begin errors++; $display("FAIL gpio_out_rd got %h exp %h", busDataOut, 32'hA5); end
    busAddress = IOB + 32'h4; gpioIn = 8'h3C;
    cyc(); cyc();
    checks++; if (busDataOut !== 32'h0) begin errors++; $display("FAIL gpio_in_early got %h exp %h", busDataOut, 32'h0); end
    cyc();
    checks++; if (busDataOut !== 32'h3C) begin errors++; $display("FAIL gpio_in got %h exp %h", busDataOut, 32'h3C); end
    // reset during a GPIO_OUT write suppresses it
    reset = 1'b1;
    bus_wr(IOB, 32'hFF);
    reset = 1'b0;
    checks++; if (gpioOut !== 8'h00) begin errors++; $display("FAIL gpio_reset_wr got %h exp %h", gpioOut, 8'h00); end
  endtask

`ifdef RISKOW_TIMER_EN
  task automatic test_timer();
    bus_wr(IOB + 32'h0C, 32'd4);
    bus_wr(IOB + 32'h08, 32'd0);
    bus_wr(IOB + 32'h10, 32'h1);            // enable; count=0 after this edge
    busAddress = IOB + 32'h08;
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL timer_irq_early got %b exp 0", timerIrq); end
    checks++; if (busDataOut !== 32'd3) begin errors++; $display("FAIL timer_count3 got %h exp %h", busDataOut, 32'd3); end
    cyc();
    checks++; if (timerIrq !== 1'b1) begin errors++; $display("FAIL timer_irq got %b exp 1", timerIrq); end
    cyc();
    checks++; if (busDataOut !== 32'd0) begin errors++; $display("FAIL timer_wrap0 got %h exp %h", busDataOut, 32'd0); end
    bus_wr(IOB + 32'h10, 32'h3);            // W1C, no match: clears
    checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL timer_w1c got %b exp 0", timerIrq); end
    busAddress = IOB + 32'h10;
    cyc(); cyc();
    checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL timer_pre_match got %b exp 0", timerIrq); end
    bus_wr(IOB + 32'h10, 32'h3);            // W1C on the match cycle
    checks++; if (timerIrq !== 1'b1) begin errors++; $display("FAIL timer_w1c_race got %b exp 1", timerIrq); end
    bus_rd(IOB + 32'h10);
    checks++; if (busDataOut !== 32'h3) begin errors++; $display("FAIL timer_ctrl got %h exp %h", busDataOut, 32'h3); end
    bus_wr(IOB + 32'h10, 32'h2);            // disable and clear
    checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL timer_off got %b exp 0", timerIrq); end
    bus_wr(IOB + 32'h08, 32'h55);
    bus_rd(IOB + 32'h08);
    checks++; if (busDataOut !== 32'h55) begin errors++; $display("FAIL timer_count_wr got %h exp %h", busDataOut, 32'h55); end
  endtask
`else
  task automatic test_no_timer();
    bus_wr(IOB + 32'h08, 32'h55);
    bus_wr(IOB + 32'h10, 32'h1);
    bus_rd(IOB + 32'h08);
    checks++; if (busDataOut !== 32'h0) begin errors++; $display("FAIL notimer_count got %h exp %h", busDataOut, 32'h0); end
    for (int i = 0; i < 8; i++) cyc();
    checks++; if (timerIrq !== 1'b0) begin errors++; $display("FAIL notimer_irq got %b exp 0", timerIrq); end
    bus_rd(IOB + 32'h10);
    checks++; if (busDataOut !== 32'h0) begin errors++; $display("FAIL notimer_ctrl got %h exp %h", busDataOut, 32'h0); end
  endtask
`endif

  initial begin
    test_reset();
    test_ram();
    test_read_before_write();
    test_unmapped();
    test_gpio();
`ifdef RISKOW_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
